// File: rtl/raster_src.sv
// Raster stream source: programmable frame timing (blanking + active area) with
// selectable test patterns, driving the vvalid/hvalid/pixel protocol.
module raster_src #(
   parameter int DW   = 8,
   parameter int HACT = 1920,
   parameter int HBLK = 280,
   parameter int VACT = 1080,
   parameter int VBLK = 45
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          en,
   input  logic [1:0]    mode,
   input  logic [DW-1:0] seed,
   output logic          vvalid,
   output logic          hvalid,
   output logic [DW-1:0] dout,
   output logic          sof,
   output logic          eof,
   output logic [15:0]   frame_cnt
);

   localparam int L    = HBLK + HACT;
   localparam int HW   = $clog2(L);
   localparam int VMAX = (VACT > VBLK) ? VACT : VBLK;
   localparam int VW   = $clog2(VMAX + 1);
   localparam int CW0  = (HW > VW) ? HW : VW;
   localparam int CW1  = (CW0 > DW) ? CW0 : DW;
   localparam int CW   = (CW1 > 4) ? CW1 : 4;

   localparam logic [HW-1:0] H_LAST  = HW'(L - 1);
   localparam logic [HW-1:0] HB_LAST = HW'(HBLK - 1);
   localparam logic [HW-1:0] HB_LEN  = HW'(HBLK);
   localparam logic [HW-1:0] X_LAST  = HW'(HACT - 1);
   localparam logic [VW-1:0] VB_LAST = VW'(VBLK - 1);
   localparam logic [VW-1:0] Y_LAST  = VW'(VACT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_VBLANK = 2'd1,
      S_HBLANK = 2'd2,
      S_ACTIVE = 2'd3
   } state_t;

   state_t          r_state;
   logic [HW-1:0]   r_hcnt;
   logic [VW-1:0]   r_vcnt;
   logic [1:0]      r_mode;
   logic [DW-1:0]   r_seed;
   logic            r_vvalid;
   logic            r_hvalid;
   logic [DW-1:0]   r_dout;
   logic            r_sof;
   logic            r_eof;
   logic [15:0]     r_frame_cnt;

   logic [HW-1:0]   w_x;
   logic [DW-1:0]   w_pix;
   logic            w_active;
   logic            w_sof;
   logic            w_eof;

   function automatic logic [DW-1:0] pattern(
      input logic [1:0]    m,
      input logic [HW-1:0] x,
      input logic [VW-1:0] y,
      input logic [DW-1:0] s
   );
      logic [CW-1:0] xe;
      logic [CW-1:0] ye;
      xe = CW'(x);
      ye = CW'(y);
      case (m)
         2'd0:    pattern = DW'(x);
         2'd1:    pattern = DW'(x) + DW'(y);
         2'd2:    pattern = (xe[3] ^ ye[3]) ? {DW{1'b1}} : {DW{1'b0}};
         default: pattern = s;
      endcase
   endfunction

   // The line counter spans blanking and active, so x is its offset past HBLK.
   always_comb begin
      w_x      = r_hcnt - HB_LEN;
      w_active = (r_state == S_ACTIVE);
      w_pix    = pattern(r_mode, w_x, r_vcnt, r_seed);
      w_sof    = w_active && (w_x == {HW{1'b0}}) && (r_vcnt == {VW{1'b0}});
      w_eof    = w_active && (w_x == X_LAST) && (r_vcnt == Y_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst_b) begin
         r_state     <= S_IDLE;
         r_hcnt      <= {HW{1'b0}};
         r_vcnt      <= {VW{1'b0}};
         r_mode      <= 2'd0;
         r_seed      <= {DW{1'b0}};
         r_vvalid    <= 1'b0;
         r_hvalid    <= 1'b0;
         r_dout      <= {DW{1'b0}};
         r_sof       <= 1'b0;
         r_eof       <= 1'b0;
         r_frame_cnt <= 16'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_hcnt <= {HW{1'b0}};
               r_vcnt <= {VW{1'b0}};
               if (en) begin
                  r_state <= S_VBLANK;
                  r_mode  <= mode;
                  r_seed  <= seed;
               end
            end
            S_VBLANK: begin
               if (r_hcnt == H_LAST) begin
                  r_hcnt <= {HW{1'b0}};
                  if (r_vcnt == VB_LAST) begin
                     r_vcnt  <= {VW{1'b0}};
                     r_state <= S_HBLANK;
                  end else begin
                     r_vcnt <= r_vcnt + VW'(1);
                  end
               end else begin
                  r_hcnt <= r_hcnt + HW'(1);
               end
            end
            S_HBLANK: begin
               r_hcnt <= r_hcnt + HW'(1);
               if (r_hcnt == HB_LAST) begin
                  r_state <= S_ACTIVE;
               end
            end
            S_ACTIVE: begin
               if (r_hcnt == H_LAST) begin
                  r_hcnt <= {HW{1'b0}};
                  if (r_vcnt != Y_LAST) begin
                     r_vcnt  <= r_vcnt + VW'(1);
                     r_state <= S_HBLANK;
                  end else begin
                     // End of frame: the only point besides IDLE where en is honoured.
                     r_vcnt <= {VW{1'b0}};
                     if (en) begin
                        r_state <= S_VBLANK;
                        r_mode  <= mode;
                        r_seed  <= seed;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end
               end else begin
                  r_hcnt <= r_hcnt + HW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase

         r_vvalid    <= (r_state == S_HBLANK) || (r_state == S_ACTIVE);
         r_hvalid    <= w_active;
         r_dout      <= w_active ? w_pix : {DW{1'b0}};
         r_sof       <= w_sof;
         r_eof       <= w_eof;
         r_frame_cnt <= r_frame_cnt + {15'd0, r_eof};
      end
   end

   assign vvalid    = r_vvalid;
   assign hvalid    = r_hvalid;
   assign dout      = r_dout;
   assign sof       = r_sof;
   assign eof       = r_eof;
   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_raster_src.sv
// Scoreboard bench for raster_src: expected pixels are queued per frame as the
// stimulus starts it and popped as the DUT asserts hvalid.
module tb_raster_src;

   logic       clk = 1'b0;
   logic       rst_b;
   logic       en_a, en_b;
   logic [1:0] mode_a, mode_b;
   logic [7:0] seed;

   logic       vv_a, hv_a, sof_a, eof_a;
   logic [7:0] dout_a;
   logic [15:0] fc_a;
   logic       vv_b, hv_b, sof_b, eof_b;
   logic [7:0] dout_b;
   logic [15:0] fc_b;

   always #5 clk = ~clk;

   raster_src #(.DW(8), .HACT(8), .HBLK(4), .VACT(4), .VBLK(2)) u_dut_a (
      .clk(clk), .rst_b(rst_b), .en(en_a), .mode(mode_a), .seed(seed),
      .vvalid(vv_a), .hvalid(hv_a), .dout(dout_a), .sof(sof_a), .eof(eof_a),
      .frame_cnt(fc_a)
   );

   raster_src #(.DW(8), .HACT(16), .HBLK(4), .VACT(16), .VBLK(2)) u_dut_b (
      .clk(clk), .rst_b(rst_b), .en(en_b), .mode(mode_b), .seed(seed),
      .vvalid(vv_b), .hvalid(hv_b), .dout(dout_b), .sof(sof_b), .eof(eof_b),
      .frame_cnt(fc_b)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       s;
      logic       e;
   } exp_t;

   exp_t sb_a[$];
   exp_t sb_b[$];
   exp_t ea, eb;
   int   sof_q[$];
   int   vv_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   eof_n = 0;
   int   exp_fc = 0;
   logic fc_pend = 1'b0;
   logic vv_prev = 1'b0;
   int   t, t3;

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] model_pix(input int m, input int x, input int y, input logic [7:0] s);
      case (m)
         0:       return 8'(x % 256);
         1:       return 8'((x + y) % 256);
         2:       return (((x / 8) ^ (y / 8)) % 2 == 1) ? 8'hFF : 8'h00;
         default: return s;
      endcase
   endfunction

   task automatic push_frame(input bit on_b, input int m, input logic [7:0] s);
      int   hact, vact;
      exp_t e;
      hact = on_b ? 16 : 8;
      vact = on_b ? 16 : 4;
      for (int y = 0; y < vact; y++) begin
         for (int x = 0; x < hact; x++) begin
            e.d = model_pix(m, x, y, s);
            e.s = (x == 0) && (y == 0);
            e.e = (x == hact - 1) && (y == vact - 1);
            if (on_b) sb_b.push_back(e);
            else      sb_a.push_back(e);
         end
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic rst_pulse();
      rst_b  = 1'b1;
      exp_fc = 0;
      repeat (2) @(negedge clk);
      rst_b = 1'b0;
      sb_a.delete();
      sb_b.delete();
      sof_q.delete();
      vv_q.delete();
      eof_n   = 0;
      fc_pend = 1'b0;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor for the 8x4 instance: scoreboard, frame counter and protocol checks.
   always @(negedge clk) begin
      if (fc_pend) begin
         exp_fc = exp_fc + 1;
         chk_eq("frame_cnt", fc_a, exp_fc);
      end
      fc_pend = eof_a;
      if (vv_a && !vv_prev) vv_q.push_back(cyc);
      vv_prev = vv_a;
      if (sof_a) sof_q.push_back(cyc);
      if (eof_a) eof_n++;
      if (hv_a) begin
         chk_eq("hv_in_vv", vv_a, 1);
         if (sb_a.size() == 0) begin
            chk_eq("sb_a_under", sb_a.size(), 1);
         end else begin
            ea = sb_a.pop_front();
            chk_eq("dout_a", dout_a, ea.d);
            chk_eq("sof_a", sof_a, ea.s);
            chk_eq("eof_a", eof_a, ea.e);
         end
      end else begin
         chk_eq("blank_a", {dout_a, sof_a, eof_a}, 0);
      end
   end

   // Monitor for the 16x16 instance used by the pattern checks.
   always @(negedge clk) begin
      if (hv_b) begin
         chk_eq("hv_in_vv_b", vv_b, 1);
         if (sb_b.size() == 0) begin
            chk_eq("sb_b_under", sb_b.size(), 1);
         end else begin
            eb = sb_b.pop_front();
            chk_eq("dout_b", dout_b, eb.d);
            chk_eq("sof_b", sof_b, eb.s);
            chk_eq("eof_b", eof_b, eb.e);
         end
      end else begin
         chk_eq("blank_b", {dout_b, sof_b, eof_b}, 0);
      end
   end

   initial begin
      rst_b  = 1'b1;
      en_a   = 1'b0;
      en_b   = 1'b0;
      mode_a = 2'd0;
      mode_b = 2'd0;
      seed   = 8'h00;
      repeat (3) @(negedge clk);
      chk_eq("rst_out", {vv_a, hv_a, dout_a, sof_a, eof_a}, 0);
      chk_eq("rst_fc", fc_a, 0);
      rst_b = 1'b0;
      @(negedge clk);

      // Start latency, ramp frames, back-to-back period over three frames.
      push_frame(0, 0, 8'h00);
      push_frame(0, 0, 8'h00);
      push_frame(0, 0, 8'h00);
      en_a = 1'b1;
      t = cyc + 1;
      wait_until(t + 150);
      en_a = 1'b0;
      wait_until(t + 230);
      chk_eq("vv_rises", vv_q.size(), 3);
      if (vv_q.size() == 3) chk_eq("vv_latency", vv_q[0] - t, 25);
      chk_eq("sof_n", sof_q.size(), 3);
      if (sof_q.size() == 3) begin
         chk_eq("sof_latency", sof_q[0] - t, 29);
         chk_eq("sof_gap1", sof_q[1] - sof_q[0], 72);
         chk_eq("sof_gap2", sof_q[2] - sof_q[1], 72);
      end
      chk_eq("fc_3", fc_a, 3);
      chk_eq("sb_a_left1", sb_a.size(), 0);
      chk_eq("idle_out1", {vv_a, hv_a, dout_a, sof_a, eof_a}, 0);

      // en dropped during line 1 of frame 2: frame completes, then idle.
      rst_pulse();
      push_frame(0, 0, 8'h00);
      push_frame(0, 0, 8'h00);
      en_a = 1'b1;
      t = cyc + 1;
      wait_until(t + 112);
      en_a = 1'b0;
      wait_until(t + 200);
      chk_eq("eof_n2", eof_n, 2);
      chk_eq("fc_2", fc_a, 2);
      chk_eq("vv_rises2", vv_q.size(), 2);
      chk_eq("sb_a_left2", sb_a.size(), 0);
      chk_eq("idle_out2", {vv_a, hv_a, dout_a, sof_a, eof_a}, 0);

      // Constant frame, mode/seed changed mid-frame, next frame is the ramp.
      rst_pulse();
      mode_a = 2'd3;
      seed   = 8'hA5;
      push_frame(0, 3, 8'hA5);
      push_frame(0, 0, 8'h00);
      en_a = 1'b1;
      t = cyc + 1;
      wait_until(t + 40);
      mode_a = 2'd0;
      seed   = 8'h3C;
      wait_until(t + 100);
      en_a = 1'b0;
      wait_until(t + 150);
      chk_eq("fc_mode", fc_a, 2);
      chk_eq("sb_a_left3", sb_a.size(), 0);

      // Reset during line 2 active: outputs clear, partial frame not counted.
      push_frame(0, 0, 8'h00);
      en_a = 1'b1;
      t = cyc + 1;
      wait_until(t + 55);
      chk_eq("mid_hv", hv_a, 1);
      rst_b  = 1'b1;
      exp_fc = 0;
      @(negedge clk);
      chk_eq("rst_mid_out", {vv_a, hv_a, dout_a, sof_a, eof_a}, 0);
      chk_eq("rst_mid_fc", fc_a, 0);
      sb_a.delete();
      sof_q.delete();
      fc_pend = 1'b0;
      rst_b = 1'b0;
      t3 = cyc + 1;
      push_frame(0, 0, 8'h00);
      wait_until(t3 + 40);
      en_a = 1'b0;
      wait_until(t3 + 80);
      chk_eq("sof_n6", sof_q.size(), 1);
      if (sof_q.size() == 1) chk_eq("sof_latency6", sof_q[0] - t3, 29);
      chk_eq("fc_6", fc_a, 1);
      chk_eq("sb_a_left6", sb_a.size(), 0);

      // Diagonal ramp then 8x8 checker on the 16x16 instance.
      rst_pulse();
      mode_b = 2'd1;
      push_frame(1, 1, 8'h00);
      push_frame(1, 2, 8'h00);
      en_b = 1'b1;
      t = cyc + 1;
      wait_until(t + 100);
      mode_b = 2'd2;
      wait_until(t + 400);
      en_b = 1'b0;
      wait_until(t + 730);
      chk_eq("fc_b", fc_b, 2);
      chk_eq("sb_b_left", sb_b.size(), 0);
      chk_eq("idle_out_b", {vv_b, hv_b, dout_b, sof_b, eof_b}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
